// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates one data port and two instruction ports onto a single RAM.
// Optional starvation guard for instruction ports: define MEM_ARBITER_FAIRNESS_EN.
module mem_arbiter #(
  parameter int WORD_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                dramREN,
  input  logic                dramWEN,
  input  logic [WORD_W-1:0]   dramaddr,
  input  logic [WORD_W-1:0]   dramstore,
  output logic [WORD_W-1:0]   dramload,
  output logic                dramwait,
  input  logic [1:0]          iREN,
  input  logic [2*WORD_W-1:0] iaddr,
  output logic [2*WORD_W-1:0] iload,
  output logic [1:0]          iwait,
  output logic                ramREN,
  output logic                ramWEN,
  output logic [WORD_W-1:0]   ramaddr,
  output logic [WORD_W-1:0]   ramstore,
  input  logic [WORD_W-1:0]   ramload,
  input  logic [1:0]          ramstate
);
  typedef enum logic [1:0] {IDLE, GNT_D, GNT_I0, GNT_I1} state_t;
  state_t state_q, state_d, arb;
  logic ptr_q, ptr_d;
  logic acc, dreq, inst_done, data_done, granted_req, force_i;
  // Completion, request and pointer bookkeeping; the pointer update is visible to this cycle's arbitration
  always_comb begin
    acc         = ramstate == 2'd2;
    dreq        = dramREN | dramWEN;
    inst_done   = acc & (state_q == GNT_I0 || state_q == GNT_I1);
    data_done   = acc & (state_q == GNT_D);
    ptr_d       = ptr_q ^ inst_done;
    granted_req = (state_q == GNT_D) ? dreq : (state_q == GNT_I0) ? iREN[0] : iREN[1];
  end
  // Winner of an arbitration: data first unless instructions are being starved, then round-robin cores
  always_comb begin
    arb = (dreq & ~force_i) ? GNT_D :
          (iREN == 2'b11)   ? (ptr_d ? GNT_I1 : GNT_I0) :
          iREN[0]           ? GNT_I0 :
          iREN[1]           ? GNT_I1 : IDLE;
  end
  // Next grant: re-arbitrate when idle or on completion, drop to IDLE if the requester withdraws early
  always_comb begin
    state_d = (state_q == IDLE || acc) ? arb : !granted_req ? IDLE : state_q;
  end
  // Grant state and round-robin pointer
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end
`ifdef MEM_ARBITER_FAIRNESS_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  // Count data completions that an instruction request sat through; saturate at the threshold
  always_comb begin
    cnt_inc = (data_done & |iREN & (cnt_q != CW'(STARVE_MAX))) ? cnt_q + 1'b1 : cnt_q;
    force_i = |iREN & (cnt_inc >= CW'(STARVE_MAX));
  end
  // Any instruction grant clears the starvation history
  always_comb begin
    cnt_d = (state_d == GNT_I0 || state_d == GNT_I1) ? '0 : cnt_inc;
  end
  // Starvation counter
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  logic unused_done;
  assign unused_done = data_done;
  // Strict data priority: a negative threshold can never trigger
  assign force_i = STARVE_MAX < 0;
`endif
  // RAM and requester steering from the registered grant
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    dramwait = 1'b1;
    dramload = '0;
    iwait    = 2'b11;
    iload    = '0;
    case (state_q)
      GNT_D: begin
        ramaddr  = dramaddr;
        ramstore = dramstore;
        ramWEN   = dramWEN;
        ramREN   = dramREN & ~dramWEN;
        dramwait = ~acc;
        dramload = ramload;
      end
      GNT_I0: begin
        ramaddr              = iaddr[WORD_W-1:0];
        ramREN               = iREN[0];
        iwait[0]             = ~acc;
        iload[WORD_W-1:0]    = ramload;
      end
      GNT_I1: begin
        ramaddr              = iaddr[2*WORD_W-1:WORD_W];
        ramREN               = iREN[1];
        iwait[1]             = ~acc;
        iload[2*WORD_W-1:WORD_W] = ramload;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter (REQ-027 expectations follow MEM_ARBITER_FAIRNESS_EN).
module tb_mem_arbiter;
  localparam int W = 32;
  localparam logic [W-1:0] RL  = 32'h1234_5678;
  localparam logic [W-1:0] DB  = 32'hDEAD_BEEF;
  localparam logic [W-1:0] DA  = 32'h0000_0100;
  localparam logic [W-1:0] IA0 = 32'h0000_2000;
  localparam logic [W-1:0] IA1 = 32'h0000_3000;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2;
  logic CLK = 1'b0, nRST = 1'b0;
  logic dramREN, dramWEN, dramwait, ramREN, ramWEN;
  logic [W-1:0] dramaddr, dramstore, dramload, ramaddr, ramstore, ramload;
  logic [1:0] iREN, iwait, ramstate;
  logic [2*W-1:0] iaddr, iload;
  typedef struct {
    string tag;
    logic ren, wen;
    logic [W-1:0] addr, store;
    logic dw;
    logic [1:0] iw;
    logic [W-1:0] dl;
    logic [2*W-1:0] il;
  } exp_t;
  exp_t sb[$];
  int n_run = 0, n_fail = 0;

  mem_arbiter #(.WORD_W(W), .STARVE_MAX(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .dramREN(dramREN), .dramWEN(dramWEN), .dramaddr(dramaddr), .dramstore(dramstore),
    .dramload(dramload), .dramwait(dramwait),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic ren, input logic wen, input logic [W-1:0] addr,
                      input logic [W-1:0] store, input logic dw, input logic [1:0] iw,
                      input logic [W-1:0] dl, input logic [2*W-1:0] il);
    exp_t e;
    e.tag = tag; e.ren = ren; e.wen = wen; e.addr = addr; e.store = store;
    e.dw = dw; e.iw = iw; e.dl = dl; e.il = il;
    sb.push_back(e);
  endtask

  task automatic e_idle(input string tag);
    push(tag, 1'b0, 1'b0, '0, '0, 1'b1, 2'b11, '0, '0);
  endtask

  task automatic e_d(input string tag, input logic ren, input logic wen, input logic dw);
    push(tag, ren, wen, DA, DB, dw, 2'b11, RL, '0);
  endtask

  task automatic e_i(input string tag, input logic k, input logic ren, input logic w);
    push(tag, ren, 1'b0, k ? IA1 : IA0, '0, 1'b1, k ? {w, 1'b1} : {1'b1, w}, '0,
         k ? {RL, {W{1'b0}}} : {{W{1'b0}}, RL});
  endtask

  task automatic sample();
    exp_t e;
    e = sb.pop_front();
    chk({e.tag, ".ramREN"},   2*W'(ramREN),   2*W'(e.ren));
    chk({e.tag, ".ramWEN"},   2*W'(ramWEN),   2*W'(e.wen));
    chk({e.tag, ".ramaddr"},  2*W'(ramaddr),  2*W'(e.addr));
    chk({e.tag, ".ramstore"}, 2*W'(ramstore), 2*W'(e.store));
    chk({e.tag, ".dramwait"}, 2*W'(dramwait), 2*W'(e.dw));
    chk({e.tag, ".iwait"},    2*W'(iwait),    2*W'(e.iw));
    chk({e.tag, ".dramload"}, 2*W'(dramload), 2*W'(e.dl));
    chk({e.tag, ".iload"},    iload,          e.il);
  endtask

  task automatic tick();
    @(negedge CLK);
    sample();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    dramREN = 1'b0; dramWEN = 1'b1; dramaddr = DA; dramstore = DB;
    iREN = 2'b11; iaddr = {IA1, IA0}; ramload = RL; ramstate = BUSY;
    #2;
    e_idle("reset"); sample();
    dramWEN = 1'b0; iREN = 2'b00; ramstate = FREE;
    @(posedge CLK); #1;
    nRST = 1'b1;
    // REQ-024: round-robin between both cores
    iREN = 2'b11; ramstate = ACC;
    e_idle("rr_idle"); tick();
    e_i("rr0", 1'b0, 1'b1, 1'b0); tick();
    e_i("rr1", 1'b1, 1'b1, 1'b0); tick();
    e_i("rr2", 1'b0, 1'b1, 1'b0); tick();
    e_i("rr3", 1'b1, 1'b1, 1'b0); tick();
    iREN = 2'b00; ramstate = FREE;
    e_i("rr_drop", 1'b0, 1'b0, 1'b1); tick();
    e_idle("rr_end"); tick();
    // REQ-023: data before instruction, instruction granted right after completion
    dramREN = 1'b1; iREN = 2'b01;
    e_idle("df_idle"); tick();
    ramstate = BUSY;
    e_d("df_b0", 1'b1, 1'b0, 1'b1); tick();
    e_d("df_b1", 1'b1, 1'b0, 1'b1); tick();
    ramstate = ACC; dramREN = 1'b0;
    e_d("df_acc", 1'b0, 1'b0, 1'b0); tick();
    ramstate = BUSY;
    e_i("df_i0", 1'b0, 1'b1, 1'b1); tick();
    ramstate = ACC; iREN = 2'b00;
    e_i("df_i0acc", 1'b0, 1'b0, 1'b0); tick();
    ramstate = FREE;
    e_idle("df_end"); tick();
    // REQ-025: read+write together is a write
    dramREN = 1'b1; dramWEN = 1'b1;
    e_idle("wr_idle"); tick();
    ramstate = BUSY;
    e_d("wr_busy", 1'b0, 1'b1, 1'b1); tick();
    ramstate = ACC;
    e_d("wr_acc", 1'b0, 1'b1, 1'b0); tick();
    ramstate = BUSY; dramREN = 1'b0; dramWEN = 1'b0;
    e_d("wr_drop", 1'b0, 1'b0, 1'b1); tick();
    e_idle("wr_end"); tick();
    // REQ-026: instruction core 1 withdraws during BUSY
    iREN = 2'b10;
    e_idle("dr_idle"); tick();
    e_i("dr_i1", 1'b1, 1'b1, 1'b1); tick();
    iREN = 2'b00;
    e_i("dr_drop", 1'b1, 1'b0, 1'b1); tick();
    dramWEN = 1'b1;
    e_idle("dr_rearb"); tick();
    // REQ-022: reset in the middle of a data write grant
    e_d("rs_busy", 1'b0, 1'b1, 1'b1);
    @(negedge CLK); sample();
    #2 nRST = 1'b0;
    #1 e_idle("rs_mid"); sample();
    @(posedge CLK); #1;
    nRST = 1'b1;
    e_idle("rs_idle"); tick();
    e_d("rs_regnt", 1'b0, 1'b1, 1'b1); tick();
    dramWEN = 1'b0;
    e_d("rs_drop", 1'b0, 1'b0, 1'b1); tick();
    e_idle("rs_end"); tick();
    // REQ-027: continuous data traffic against a waiting core 0
    dramREN = 1'b1; iREN = 2'b01; ramstate = ACC;
    e_idle("fr_idle"); tick();
    for (int i = 0; i < 4; i++) begin
      e_d($sformatf("fr_d%0d", i), 1'b1, 1'b0, 1'b0); tick();
    end
`ifdef MEM_ARBITER_FAIRNESS_EN
    e_i("fr_i0", 1'b0, 1'b1, 1'b0); tick();
    e_d("fr_after", 1'b1, 1'b0, 1'b0); tick();
`else
    for (int i = 4; i < 8; i++) begin
      e_d($sformatf("fr_d%0d", i), 1'b1, 1'b0, 1'b0); tick();
    end
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
